// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: EX operand-select codes and
// the load-use stall FSM states.
package hazard_pkg;

  localparam int DEF_REG_AW   = 5;
  localparam int DEF_ZERO_REG = 31;
  localparam int DEF_MEM_LAT  = 1;
  localparam int DEF_CNT_W    = 16;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    HZ_IDLE    = 1'b0,
    HZ_LD_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// One EX source operand: compares against the MEM and WB destinations and picks
// the youngest producer. The zero register is never forwarded.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  output fwd_sel_t          sel
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && (mem_rd == src) && (mem_rd != ZR);
  assign wb_hit  = wb_reg_write  && (wb_rd  == src) && (wb_rd  != ZR);

  // MEM holds the more recent value, so it wins when both stages match.
  always_comb begin
    sel = FWD_RF;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: EX operand forwarding, load-use
// stall sequencing over a multi-cycle data memory, taken-branch flush, perf counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEF_REG_AW,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int MEM_LAT  = DEF_MEM_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rn,
  input  logic [REG_AW-1:0] dec_rm,
  input  logic              dec_use_rn,
  input  logic              dec_use_rm,
  input  logic [REG_AW-1:0] ex_aa,
  input  logic [REG_AW-1:0] ex_ab,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic              br_taken,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if,
  output logic              stall_dec,
  output logic              bubble_ex,
  output logic              flush_dec,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int                LAT_W = $clog2(MEM_LAT + 1);
  localparam logic [REG_AW-1:0] ZR    = REG_AW'(ZERO_REG);

  hz_state_t        state;
  logic [LAT_W-1:0] lat_cnt;
  fwd_sel_t         sel_a;
  fwd_sel_t         sel_b;
  logic             load_use;
  logic             stall;

  // A load always writes its destination, so ex_mem_read alone identifies the hazard.
  logic unused_ex_reg_write;
  assign unused_ex_reg_write = ex_reg_write;

  hazard_fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src           (ex_aa),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_a)
  );

  hazard_fwd_sel #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src           (ex_ab),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .sel           (sel_b)
  );

  assign load_use = dec_valid && ex_mem_read && (ex_rd != ZR) &&
                    ((dec_use_rn && (dec_rn == ex_rd)) ||
                     (dec_use_rm && (dec_rm == ex_rd)));

  // Branch flush squashes the dependent instruction, so it overrides any stall.
  assign stall = !reset && !br_taken && ((state == HZ_LD_WAIT) || load_use);

  always_comb begin
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    flush_dec = 1'b0;
    if (!reset) begin
      fwd_a     = sel_a;
      fwd_b     = sel_b;
      flush_dec = br_taken;
    end
  end

  assign stall_if  = stall;
  assign stall_dec = stall;
  assign bubble_ex = stall;

  // The IDLE detect cycle is the first stall cycle; LD_WAIT covers the remaining MEM_LAT-1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HZ_IDLE;
      lat_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (br_taken) begin
        state   <= HZ_IDLE;
        lat_cnt <= '0;
      end else begin
        case (state)
          HZ_IDLE: begin
            if (load_use && (MEM_LAT > 1)) begin
              state   <= HZ_LD_WAIT;
              lat_cnt <= LAT_W'(MEM_LAT - 1);
            end
          end
          HZ_LD_WAIT: begin
            lat_cnt <= lat_cnt - LAT_W'(1);
            if (lat_cnt == LAT_W'(1)) state <= HZ_IDLE;
          end
          default: begin
            state   <= HZ_IDLE;
            lat_cnt <= '0;
          end
        endcase
      end

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_dec && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: combinational forwarding/hazard table on a MEM_LAT=1 instance,
// then multi-cycle stall, flush, reset-abort and counter-saturation sequences.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       dec_valid, dec_use_rn, dec_use_rm;
  logic [4:0] dec_rn, dec_rm, ex_aa, ex_ab, ex_rd, mem_rd, wb_rd;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write, br_taken;

  // index 0: MEM_LAT=1, 1: MEM_LAT=3, 2: MEM_LAT=1 with CNT_W=2
  logic [1:0]  fa [3];
  logic [1:0]  fb [3];
  logic        sif [3];
  logic        sdec [3];
  logic        bex [3];
  logic        fdec [3];
  logic [15:0] scnt [2];
  logic [15:0] fcnt [2];
  logic [1:0]  scnt_s, fcnt_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_LAT(1)) u1 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
    .dec_use_rn(dec_use_rn), .dec_use_rm(dec_use_rm), .ex_aa(ex_aa), .ex_ab(ex_ab),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .br_taken(br_taken), .fwd_a(fa[0]), .fwd_b(fb[0]),
    .stall_if(sif[0]), .stall_dec(sdec[0]), .bubble_ex(bex[0]), .flush_dec(fdec[0]),
    .stall_cnt(scnt[0]), .flush_cnt(fcnt[0]));

  pipe_hazard_ctrl #(.MEM_LAT(3)) u3 (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
    .dec_use_rn(dec_use_rn), .dec_use_rm(dec_use_rm), .ex_aa(ex_aa), .ex_ab(ex_ab),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .br_taken(br_taken), .fwd_a(fa[1]), .fwd_b(fb[1]),
    .stall_if(sif[1]), .stall_dec(sdec[1]), .bubble_ex(bex[1]), .flush_dec(fdec[1]),
    .stall_cnt(scnt[1]), .flush_cnt(fcnt[1]));

  pipe_hazard_ctrl #(.MEM_LAT(1), .CNT_W(2)) us (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_rn(dec_rn), .dec_rm(dec_rm),
    .dec_use_rn(dec_use_rn), .dec_use_rm(dec_use_rm), .ex_aa(ex_aa), .ex_ab(ex_ab),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .br_taken(br_taken), .fwd_a(fa[2]), .fwd_b(fb[2]),
    .stall_if(sif[2]), .stall_dec(sdec[2]), .bubble_ex(bex[2]), .flush_dec(fdec[2]),
    .stall_cnt(scnt_s), .flush_cnt(fcnt_s));

  typedef struct {
    logic       dv;
    logic [4:0] rn, rm;
    logic       urn, urm;
    logic [4:0] aa, ab, exrd;
    logic       mrd;
    logic [4:0] mdst;
    logic       mwe;
    logic [4:0] wdst;
    logic       wwe;
    logic       br;
    logic [7:0] exp;   // {fwd_a, fwd_b, stall_if, stall_dec, bubble_ex, flush_dec}
  } vec_t;

  vec_t vecs [13];

  function automatic logic [7:0] outs(input int i);
    return {fa[i], fb[i], sif[i], sdec[i], bex[i], fdec[i]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clear_in();
    dec_valid = 0; dec_rn = 0; dec_rm = 0; dec_use_rn = 0; dec_use_rm = 0;
    ex_aa = 0; ex_ab = 0; ex_rd = 0; ex_reg_write = 0; ex_mem_read = 0;
    mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0; br_taken = 0;
  endtask

  // LDUR X2 in EX, ADD reading X2 in DEC
  task automatic set_lu();
    dec_valid = 1; dec_rn = 5'd2; dec_use_rn = 1;
    ex_rd = 5'd2; ex_reg_write = 1; ex_mem_read = 1;
  endtask

  task automatic apply(input vec_t v);
    dec_valid = v.dv; dec_rn = v.rn; dec_rm = v.rm; dec_use_rn = v.urn; dec_use_rm = v.urm;
    ex_aa = v.aa; ex_ab = v.ab; ex_rd = v.exrd; ex_reg_write = v.mrd; ex_mem_read = v.mrd;
    mem_rd = v.mdst; mem_reg_write = v.mwe; wb_rd = v.wdst; wb_reg_write = v.wwe;
    br_taken = v.br;
  endtask

  // Leaves the bench just after a negedge with reset low and inputs cleared.
  task automatic do_reset();
    @(negedge clk); reset = 1; clear_in();
    @(negedge clk); reset = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    //           dv rn  rm urn urm aa  ab exrd mrd mdst mwe wdst wwe br  exp
    vecs[0]  = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd3,  5'd0,  5'd0,  1'b0, 5'd3,  1'b1, 5'd3,  1'b1, 1'b0, 8'b10_00_0000};
    vecs[1]  = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd3,  5'd0,  5'd0,  1'b0, 5'd3,  1'b0, 5'd3,  1'b1, 1'b0, 8'b01_00_0000};
    vecs[2]  = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  5'd31, 5'd0,  1'b0, 5'd31, 1'b1, 5'd0,  1'b0, 1'b0, 8'b00_00_0000};
    vecs[3]  = '{1'b1, 5'd31, 5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd31, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 8'b00_00_0000};
    vecs[4]  = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd5,  5'd5,  5'd0,  1'b0, 5'd9,  1'b1, 5'd5,  1'b1, 1'b0, 8'b01_01_0000};
    vecs[5]  = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd0,  5'd7,  5'd0,  1'b0, 5'd7,  1'b1, 5'd7,  1'b1, 1'b0, 8'b00_10_0000};
    vecs[6]  = '{1'b1, 5'd0,  5'd2, 1'b0, 1'b1, 5'd0,  5'd0,  5'd2,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 8'b00_00_1110};
    vecs[7]  = '{1'b1, 5'd0,  5'd2, 1'b0, 1'b0, 5'd0,  5'd0,  5'd2,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 8'b00_00_0000};
    vecs[8]  = '{1'b0, 5'd2,  5'd2, 1'b1, 1'b1, 5'd0,  5'd0,  5'd2,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 8'b00_00_0000};
    vecs[9]  = '{1'b1, 5'd2,  5'd0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd2,  1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 8'b00_00_0001};
    vecs[10] = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd31, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 5'd31, 1'b1, 1'b0, 8'b00_00_0000};
    vecs[11] = '{1'b1, 5'd4,  5'd0, 1'b1, 1'b0, 5'd4,  5'd0,  5'd4,  1'b0, 5'd4,  1'b1, 5'd0,  1'b0, 1'b0, 8'b10_00_0000};
    vecs[12] = '{1'b0, 5'd0,  5'd0, 1'b0, 1'b0, 5'd6,  5'd8,  5'd0,  1'b0, 5'd6,  1'b1, 5'd8,  1'b1, 1'b0, 8'b10_01_0000};

    // Reset holds every output low even with a hazard, matches and a branch present.
    reset = 1; clear_in(); set_lu(); br_taken = 1;
    mem_rd = 5'd3; mem_reg_write = 1; ex_aa = 5'd3; ex_ab = 5'd3;
    @(negedge clk); @(negedge clk); #1;
    check("reset_outs_lat1", 32'(outs(0)), 32'd0);
    check("reset_outs_lat3", 32'(outs(1)), 32'd0);
    check("reset_stall_cnt", 32'(scnt[0]), 32'd0);
    check("reset_flush_cnt", 32'(fcnt[0]), 32'd0);

    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i]);
      #1 check($sformatf("vec%0d", i), 32'(outs(0)), 32'(vecs[i].exp));
      @(negedge clk);
    end

    // MEM_LAT=1: single stall cycle
    do_reset(); set_lu();
    #1 check("lat1_stall", 32'(outs(0)), 32'h0E);
    @(negedge clk); clear_in();
    #1 check("lat1_release", 32'(outs(0)), 32'h00);
    check("lat1_stall_cnt", 32'(scnt[0]), 32'd1);

    // MEM_LAT=3: three consecutive stall cycles, then released
    do_reset(); set_lu();
    #1 check("lat3_c1", 32'(outs(1)), 32'h0E);
    @(negedge clk); clear_in();
    #1 check("lat3_c2", 32'(outs(1)), 32'h0E);
    @(negedge clk);
    #1 check("lat3_c3", 32'(outs(1)), 32'h0E);
    @(negedge clk);
    #1 check("lat3_release", 32'(outs(1)), 32'h00);
    check("lat3_stall_cnt", 32'(scnt[1]), 32'd3);

    // MEM_LAT=3: branch in second stall cycle wins and drops the FSM to IDLE
    do_reset(); set_lu();
    #1 check("flush_c1", 32'(outs(1)), 32'h0E);
    @(negedge clk); clear_in(); br_taken = 1;
    #1 check("flush_c2", 32'(outs(1)), 32'h01);
    @(negedge clk); br_taken = 0;
    #1 check("flush_c3_idle", 32'(outs(1)), 32'h00);
    check("flush_stall_cnt", 32'(scnt[1]), 32'd1);
    check("flush_flush_cnt", 32'(fcnt[1]), 32'd1);

    // Reset asserted while in LD_WAIT aborts the remaining stall
    do_reset(); set_lu();
    #1 check("rst_ldw_c1", 32'(outs(1)), 32'h0E);
    @(negedge clk); reset = 1; clear_in();
    #1 check("rst_ldw_during", 32'(outs(1)), 32'h00);
    @(negedge clk); reset = 0;
    #1 check("rst_ldw_after", 32'(outs(1)), 32'h00);
    check("rst_ldw_cnt", 32'(scnt[1]), 32'd0);

    // 2-bit counters saturate at 3
    do_reset(); set_lu();
    repeat (3) @(negedge clk);
    #1 check("sat_stall_3", 32'(scnt_s), 32'd3);
    @(negedge clk); clear_in();
    #1 check("sat_stall_4", 32'(scnt_s), 32'd3);
    check("wide_stall_4", 32'(scnt[0]), 32'd4);
    br_taken = 1;
    repeat (5) @(negedge clk);
    br_taken = 0;
    #1 check("sat_flush_5", 32'(fcnt_s), 32'd3);
    check("wide_flush_5", 32'(fcnt[0]), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
